ex_mdu_seq: RTL
===============

// Module: ex_mdu_seq
// PURPOSE
//  Multi-cycle sequencer for HI/LO-writing ops (MADD/MADDU/MSUB/MSUBU/DIV/DIVU) in EX stage.
//  Holds the pipeline via stallreq_o while it works. Delivers the final {hi,lo} plus a
//  one-cycle whilo_o that EX forwards as ex_hi/ex_lo/ex_whilo into the EX/MEM register.
// PARAMETERS
//  DATA_W  32  operand / HI / LO width; divide runs DATA_W iterations
// PORTS
//  clk            in   1       clock, rising edge
//  rst            in   1       async reset, active-low (asserted when 0)
//  start_i        in   1       EX holds a valid multi-cycle op (level, held while stalled)
//  op_i           in   3       000 MADD,001 MADDU,010 MSUB,011 MSUBU,100 DIV,101 DIVU; else none
//  opdata1_i      in   DATA_W  rs (multiplicand / dividend)
//  opdata2_i      in   DATA_W  rt (multiplier / divisor)
//  hi_i, lo_i     in   DATA_W  current HI/LO, already forwarded by EX
//  annul_i        in   1       cancel current op (flush)
//  stallreq_o     out  1       stall request to pipeline controller
//  busy_o         out  1       state != IDLE
//  result_hi_o    out  DATA_W  HI result (valid when whilo_o)
//  result_lo_o    out  DATA_W  LO result (valid when whilo_o)
//  whilo_o        out  1       result valid / HI-LO write enable
//  div_zero_o     out  1       divide-by-zero flag, valid with whilo_o
// BEHAVIOUR
//  - Reset (rst=0, async): state IDLE; result_hi_o/result_lo_o=0; div_zero_o=0; cnt=0.
//    Consequently whilo_o=0, busy_o=0, stallreq_o=0 while rst=0. Reset mid-op abandons the op.
//  - States: IDLE, MAC, DIV_ZERO, DIV_RUN, DONE.
//  - Accept: in IDLE, start_i=1, op_i valid and annul_i=0 -> op latched at edge. start_i is
//    ignored in every other state.
//  - stallreq_o (combinational) = accept-cond in IDLE | state in {MAC, DIV_ZERO, DIV_RUN}.
//    In DONE, stallreq_o=0 so the instruction advances on that edge.
//  - whilo_o = (state==DONE) & ~annul_i. DONE -> IDLE unconditionally. A back-to-back op is
//    accepted in the following IDLE cycle.
//  - MADD*/MSUB*: IDLE->MAC latches the 2*DATA_W product (signed for MADD/MSUB, unsigned for
//    *U) and {hi_i,lo_i}. MAC->DONE: result = {hi,lo} + prod (MADD*) or - prod (MSUB*),
//    modulo 2^(2*DATA_W). Start cycle T: MAC at T+1, DONE at T+2. Stall is high in T and T+1.
//  - DIV*: on accept, if opdata2_i==0 -> DIV_ZERO (1 cycle) -> DONE with hi=lo=0, div_zero_o=1.
//    Otherwise -> DIV_RUN with cnt=0. DIV latches |a|,|b| and the signs; DIVU latches raw values.
//    DIV_RUN: one restoring shift-subtract step per cycle, cnt++. At cnt==DATA_W-1 -> DONE.
//    DONE: lo = quotient, hi = remainder. For DIV, negate the quotient if the operand signs
//    differ; the remainder takes the dividend's sign. Start at T -> DONE at T+DATA_W+1.
//    div_zero_o=0 for nonzero divisor.
//  - Most-negative / -1 (DIV): the quotient wraps to 0x80000000 and the remainder is 0.
//  - annul_i=1 in MAC/DIV_ZERO/DIV_RUN/DONE: next state IDLE, no whilo_o. In IDLE it blocks
//    acceptance. Results are not updated by an annulled op.
//  - Operand inputs are sampled only at accept; later changes are ignored.
// TESTING
//  1 MADD hi_i=0,lo_i=5,a=3,b=4 at T -> stall T..T+1; T+2 whilo=1, hi=0, lo=0x11.
//  2 MSUBU hi=lo=0,a=1,b=1 -> T+2 hi=lo=0xFFFFFFFF. MSUB lo=10,a=-2,b=3 -> lo=16, hi=0.
//  3 DIV a=-7,b=2 -> stall 33 cycles; T+33 lo=0xFFFFFFFD, hi=0xFFFFFFFF, div_zero=0.
//    DIVU 0xFFFFFFFF/0x10 -> lo=0x0FFFFFFF, hi=0xF.
//  4 DIV b=0 -> T+2 whilo=1, hi=lo=0, div_zero=1. DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
//  5 DIV started, annul_i at T+10 -> IDLE at T+11, whilo never set, stall drops.
//    A new MADD accepted at T+11.
//  6 rst=0 asserted mid-DIV_RUN (between edges) -> outputs 0 immediately.
//    After release, start_i accepted normally; back-to-back MADD,MADD -> whilo at T+2 and T+5.

Source files
------------

// File: rtl/ex_mdu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : ex_mdu_seq
//  Purpose  : EX-stage multi-cycle sequencer for MADD/MADDU/MSUB/MSUBU/DIV/DIVU.
//             It stalls the pipeline while busy and produces a one-cycle
//             HI/LO write.
//  Revision : 1.0  initial release
// ============================================================================
module ex_mdu_seq #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [2:0]        op_i,
    input  logic [DATA_W-1:0] opdata1_i,
    input  logic [DATA_W-1:0] opdata2_i,
    input  logic [DATA_W-1:0] hi_i,
    input  logic [DATA_W-1:0] lo_i,
    input  logic              annul_i,
    output logic              stallreq_o,
    output logic              busy_o,
    output logic [DATA_W-1:0] result_hi_o,
    output logic [DATA_W-1:0] result_lo_o,
    output logic              whilo_o,
    output logic              div_zero_o
);

    localparam int c_CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_MAC      = 3'd1,
        S_DIV_ZERO = 3'd2,
        S_DIV_RUN  = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [c_CNT_W-1:0]  r_cnt;
    logic [2*DATA_W-1:0] r_acc;
    logic [2*DATA_W-1:0] r_prod;
    logic                r_sub;
    logic [DATA_W-1:0]   r_quo;
    logic [DATA_W-1:0]   r_rem;
    logic [DATA_W-1:0]   r_dvs;
    logic                r_neg_q;
    logic                r_neg_r;
    logic [DATA_W-1:0]   r_res_hi;
    logic [DATA_W-1:0]   r_res_lo;
    logic                r_div_zero;

    logic                w_op_valid;
    logic                w_accept;
    logic                w_signed;
    logic                w_a_neg;
    logic                w_b_neg;
    logic [2*DATA_W-1:0] w_a_ext;
    logic [2*DATA_W-1:0] w_b_ext;
    logic [2*DATA_W-1:0] w_prod;
    logic [2*DATA_W-1:0] w_mac;
    logic [DATA_W-1:0]   w_a_abs;
    logic [DATA_W-1:0]   w_b_abs;
    logic [DATA_W:0]     w_rem_sh;
    logic [DATA_W:0]     w_diff;
    logic                w_ge;
    logic [DATA_W-1:0]   w_rem_nx;
    logic [DATA_W-1:0]   w_quo_nx;
    logic [DATA_W-1:0]   w_q_fin;
    logic [DATA_W-1:0]   w_r_fin;

    // rst is folded in so that no stall is requested while reset is held
    assign w_op_valid = ~(op_i[2] & op_i[1]);
    assign w_accept   = rst & (r_state == S_IDLE) & start_i & w_op_valid & ~annul_i;
    assign w_signed   = ~op_i[0];
    assign w_a_neg    = w_signed & opdata1_i[DATA_W-1];
    assign w_b_neg    = w_signed & opdata2_i[DATA_W-1];

    assign w_a_ext = {{DATA_W{w_a_neg}}, opdata1_i};
    assign w_b_ext = {{DATA_W{w_b_neg}}, opdata2_i};
    assign w_prod  = w_a_ext * w_b_ext;
    assign w_mac   = r_sub ? (r_acc - r_prod) : (r_acc + r_prod);

    assign w_a_abs = w_a_neg ? (~opdata1_i + 1'b1) : opdata1_i;
    assign w_b_abs = w_b_neg ? (~opdata2_i + 1'b1) : opdata2_i;

    // Remainder stays below the divisor, so the (DATA_W+1)-bit difference
    // never overflows and its MSB is a clean borrow flag.
    assign w_rem_sh = {r_rem, r_quo[DATA_W-1]};
    assign w_diff   = w_rem_sh - {1'b0, r_dvs};
    assign w_ge     = ~w_diff[DATA_W];
    assign w_rem_nx = w_ge ? w_diff[DATA_W-1:0] : w_rem_sh[DATA_W-1:0];
    assign w_quo_nx = {r_quo[DATA_W-2:0], w_ge};
    assign w_q_fin  = r_neg_q ? (~w_quo_nx + 1'b1) : w_quo_nx;
    assign w_r_fin  = r_neg_r ? (~w_rem_nx + 1'b1) : w_rem_nx;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (!op_i[2])
                        w_next = S_MAC;
                    else if (opdata2_i == '0)
                        w_next = S_DIV_ZERO;
                    else
                        w_next = S_DIV_RUN;
                end
            end
            S_MAC, S_DIV_ZERO: w_next = annul_i ? S_IDLE : S_DONE;
            S_DIV_RUN: begin
                if (annul_i)
                    w_next = S_IDLE;
                else if (r_cnt == c_LAST)
                    w_next = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_prod     <= '0;
            r_sub      <= 1'b0;
            r_quo      <= '0;
            r_rem      <= '0;
            r_dvs      <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_res_hi   <= '0;
            r_res_lo   <= '0;
            r_div_zero <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_cnt   <= '0;
                r_acc   <= {hi_i, lo_i};
                r_prod  <= w_prod;
                r_sub   <= op_i[1];
                r_quo   <= w_a_abs;
                r_dvs   <= w_b_abs;
                r_rem   <= '0;
                r_neg_q <= w_a_neg ^ w_b_neg;
                r_neg_r <= w_a_neg;
            end else if (r_state == S_DIV_RUN) begin
                r_cnt <= r_cnt + 1'b1;
                r_rem <= w_rem_nx;
                r_quo <= w_quo_nx;
            end
            // results move only on a non-annulled entry into DONE
            if (w_next == S_DONE) begin
                case (r_state)
                    S_MAC: begin
                        r_res_hi   <= w_mac[2*DATA_W-1:DATA_W];
                        r_res_lo   <= w_mac[DATA_W-1:0];
                        r_div_zero <= 1'b0;
                    end
                    S_DIV_ZERO: begin
                        r_res_hi   <= '0;
                        r_res_lo   <= '0;
                        r_div_zero <= 1'b1;
                    end
                    default: begin
                        r_res_hi   <= w_r_fin;
                        r_res_lo   <= w_q_fin;
                        r_div_zero <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign stallreq_o  = w_accept | (r_state == S_MAC) | (r_state == S_DIV_ZERO)
                       | (r_state == S_DIV_RUN);
    assign busy_o      = (r_state != S_IDLE);
    assign whilo_o     = (r_state == S_DONE) & ~annul_i;
    assign result_hi_o = r_res_hi;
    assign result_lo_o = r_res_lo;
    assign div_zero_o  = r_div_zero;

endmodule
`default_nettype wire
